mat_mem_responder: RTL and testbench
====================================

MAT_MEM_RESPONDER -- requirements
Module: mat_mem_responder

Interface
REQ-001 Parameter: AW, 10, address width.
REQ-002 Parameter: DW, 32, data width (four packed 8-bit elements, element 0 in [7:0]).
REQ-003 Parameter: DEPTH, 1024, word count (= 2**AW).
REQ-004 Reset rstn is synchronous and active-low; clock is clk.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rstn  in  1  synchronous active-low reset.
REQ-007 read_en_A  in  1  port A read request (matrix A fetch).
REQ-008 addr_A  in  AW  port A word address.
REQ-009 data_out_A  out  DW  port A read data, registered.
REQ-010 read_en_B  in  1  port B read request (matrix B fetch).
REQ-011 addr_B  in  AW  port B word address.
REQ-012 data_out_B  out  DW  port B read data, registered.
REQ-013 write_en_C  in  1  port C write strobe (result write-back).
REQ-014 addr_C  in  AW  port C word address.
REQ-015 data_in_C  in  DW  port C write data.
REQ-016 clr_start  in  1  one-cycle pulse that starts a region clear.
REQ-017 clr_base  in  AW  first address of the clear region, sampled on an accepted clr_start.
REQ-018 clr_len  in  AW+1  number of words to clear, sampled on an accepted clr_start; the range is 0..DEPTH.
REQ-019 busy  out  1  high while the clear sequencer is not IDLE.
REQ-020 clr_done  out  1  one-cycle pulse when a clear completes.
REQ-021 wr_count  out  16  count of port-C writes accepted since reset.

Function
REQ-022 Read latency is 1 cycle: if read_en_X is high at edge N, data_out_X holds mem[addr_X] after edge N.
REQ-023 data_out_X holds its last value while read_en_X is low.
REQ-024 Ports A and B are independent and may read the same address in the same cycle.
REQ-025 If write_en_C is high at edge N, mem[addr_C] is updated with data_in_C at edge N.
REQ-026 A port-A or port-B read at the same address as a same-cycle port-C write follows the REQ-046/047 collision rule.
REQ-027 wr_count increments by 1 on every port-C write, saturating at 0xFFFF.
REQ-028 The clear FSM has three states: IDLE, CLEAR and DONE.
REQ-029 IDLE: clr_start high -> latch clr_base and clr_len, reset the index to 0, go to CLEAR.
REQ-030 CLEAR: each cycle without a port-C write, write 0 to mem[(clr_base+index) mod DEPTH], then increment the index.
REQ-031 CLEAR: when index equals clr_len, no write occurs and the FSM goes to DONE.
REQ-032 CLEAR with clr_len = 0: no words are written, and DONE follows one cycle after acceptance.
REQ-033 CLEAR: the address wraps from DEPTH-1 to 0.
REQ-034 DONE: clr_done is high for exactly this one cycle, then the FSM goes to IDLE.
REQ-035 A port-C write has priority over the clear write; the sequencer stalls that cycle and the index holds.
REQ-036 clr_start is ignored while busy is high.
REQ-037 busy is high in CLEAR and DONE.
REQ-038 Reads are serviced normally during CLEAR.
REQ-039 A read of the word being cleared in the same cycle returns its old value.
REQ-040 The clear cycle count is clr_len + 2 plus one cycle per stall.

Reset
REQ-041 While rstn is low at a clock edge, data_out_A and data_out_B are set to 0.
REQ-042 While rstn is low at a clock edge, wr_count, busy and clr_done are set to 0 and the FSM goes to IDLE.
REQ-043 Reset during CLEAR aborts the clear; words already zeroed stay zero, and no clr_done is issued.
REQ-044 Memory contents are not cleared by reset and are preloadable by hierarchical access to array "memory".
REQ-045 Port reads and writes are ignored while rstn is low.

Configuration
REQ-046 With macro MEM_WR_BYPASS_EN defined, a same-cycle read at the same address as a port-C write returns data_in_C (write-first).
REQ-047 Without MEM_WR_BYPASS_EN, a same-cycle read at the same address as a port-C write returns the pre-write contents (read-first); memory is updated in both cases.

Verification
REQ-048 Read latency: preload mem[0x000]=0x08070605, read_en_A at edge N -> data_out_A=0x08070605 after N and held after read_en_A drops.
REQ-049 Write and read-back: write 0x9BBFFFFF to 0x200, then read on port B -> 0x9BBFFFFF, wr_count=1.
REQ-050 Collision: mem[0x200]=0x11111111; write 0x22222222 and read 0x200 on port A in the same cycle -> 0x22222222 with the macro, 0x11111111 without; a later read returns 0x22222222.
REQ-051 Clear wrap: clr_base=0x3FE, clr_len=4 -> words 0x3FE, 0x3FF, 0x000, 0x001 become 0; busy lasts 6 cycles; clr_done is a single pulse.
REQ-052 Stall and abort: a port-C write during CLEAR extends busy by one cycle with no word skipped; rstn low mid-clear -> busy=0, no clr_done, the remaining words are unchanged.
REQ-053 Edge cases: clr_len=0 -> no writes and clr_done two cycles after clr_start; clr_start while busy is ignored; 0x10000 writes -> wr_count stays at 0xFFFF.

Source files
------------

// File: rtl/mat_mem_responder.sv
// Three-port matrix memory (reads A/B, write-back C) with a region-clear sequencer.
// Define MEM_WR_BYPASS_EN for write-first read/write collisions; the default is read-first.
module mat_mem_responder #(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          read_en_A,
    input  logic [AW-1:0] addr_A,
    output logic [DW-1:0] data_out_A,
    input  logic          read_en_B,
    input  logic [AW-1:0] addr_B,
    output logic [DW-1:0] data_out_B,
    input  logic          write_en_C,
    input  logic [AW-1:0] addr_C,
    input  logic [DW-1:0] data_in_C,
    input  logic          clr_start,
    input  logic [AW-1:0] clr_base,
    input  logic [AW:0]   clr_len,
    output logic          busy,
    output logic          clr_done,
    output logic [15:0]   wr_count
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    logic [DW-1:0] memory [0:DEPTH-1];

    clr_state_t    state;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   idx_q;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    // The AW-bit sum wraps modulo DEPTH because DEPTH is 2**AW.
    assign clr_addr = base_q + idx_q[AW-1:0];
    assign clr_we   = (state == CLEAR) && (idx_q != len_q);

    // Port C wins over the clear write; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (write_en_C)
                memory[addr_C] <= data_in_C;
            else if (clr_we)
                memory[clr_addr] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_out_A <= '0;
            data_out_B <= '0;
        end else begin
`ifdef MEM_WR_BYPASS_EN
            if (read_en_A)
                data_out_A <= (write_en_C && addr_C == addr_A) ? data_in_C : memory[addr_A];
            if (read_en_B)
                data_out_B <= (write_en_C && addr_C == addr_B) ? data_in_C : memory[addr_B];
`else
            if (read_en_A)
                data_out_A <= memory[addr_A];
            if (read_en_B)
                data_out_B <= memory[addr_B];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            wr_count <= '0;
        else if (write_en_C && wr_count != 16'hFFFF)
            wr_count <= wr_count + 16'd1;
    end

    // Clear sequencer; a port-C write stalls the index for that cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_start) begin
                        base_q <= clr_base;
                        len_q  <= clr_len;
                        idx_q  <= '0;
                        state  <= CLEAR;
                        busy   <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx_q == len_q) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end else if (!write_en_C) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mem_responder.sv
// Directed self-checking bench for mat_mem_responder; honours MEM_WR_BYPASS_EN for collision expectations.
module tb_mat_mem_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        read_en_A, read_en_B, write_en_C, clr_start;
    logic [9:0]  addr_A, addr_B, addr_C, clr_base;
    logic [10:0] clr_len;
    logic [31:0] data_in_C, data_out_A, data_out_B;
    logic        busy, clr_done;
    logic [15:0] wr_count;

    int vectors = 0;
    int miscompares = 0;
    int busyCycles, doneCount, doneAt;

    mat_mem_responder #(.AW(10), .DW(32), .DEPTH(1024)) dut (
        .clk(clk), .rstn(rstn),
        .read_en_A(read_en_A), .addr_A(addr_A), .data_out_A(data_out_A),
        .read_en_B(read_en_B), .addr_B(addr_B), .data_out_B(data_out_B),
        .write_en_C(write_en_C), .addr_C(addr_C), .data_in_C(data_in_C),
        .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len),
        .busy(busy), .clr_done(clr_done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Starts a clear, optionally stalls it with a port-C write and retries clr_start mid-clear.
    task automatic applyStimulus(input logic [9:0] base, input logic [10:0] len, input int stallAt,
                                 input int restartAt, output int nBusy, output int nDone, output int firstDone);
        clr_base  = base;
        clr_len   = len;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        nBusy = 0; nDone = 0; firstDone = -1;
        for (int c = 0; c < 3000 && busy; c++) begin
            nBusy++;
            if (clr_done) begin
                nDone++;
                if (firstDone < 0) firstDone = c;
            end
            write_en_C = (c == stallAt);
            addr_C     = 10'h300;
            data_in_C  = 32'h0000_0005;
            clr_start  = (c == restartAt);
            clr_base   = 10'h050;
            clr_len    = 11'd2;
            tick();
        end
        write_en_C = 1'b0;
        clr_start  = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; read_en_A = 0; read_en_B = 0; write_en_C = 0; clr_start = 0;
        addr_A = 0; addr_B = 0; addr_C = 0; data_in_C = 0; clr_base = 0; clr_len = 0;
        dut.memory[10'h000] = 32'h0807_0605;
        tick(); tick();
        checkOutput("rst_data_out_A", data_out_A, 32'h0);
        checkOutput("rst_data_out_B", data_out_B, 32'h0);
        checkOutput("rst_wr_count", {16'h0, wr_count}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_clr_done", {31'h0, clr_done}, 32'h0);

        // Read latency and hold
        rstn = 1'b1;
        read_en_A = 1'b1; addr_A = 10'h000;
        tick();
        checkOutput("read_latency_A", data_out_A, 32'h0807_0605);
        read_en_A = 1'b0; addr_A = 10'h005;
        tick(); tick();
        checkOutput("read_hold_A", data_out_A, 32'h0807_0605);

        // Write then read back on port B
        write_en_C = 1'b1; addr_C = 10'h200; data_in_C = 32'h9BBF_FFFF;
        tick();
        write_en_C = 1'b0; read_en_B = 1'b1; addr_B = 10'h200;
        tick();
        read_en_B = 1'b0;
        checkOutput("readback_B", data_out_B, 32'h9BBF_FFFF);
        checkOutput("wr_count_one", {16'h0, wr_count}, 32'h1);

        // Same-cycle collision on port A
        dut.memory[10'h200] = 32'h1111_1111;
        write_en_C = 1'b1; addr_C = 10'h200; data_in_C = 32'h2222_2222;
        read_en_A = 1'b1; addr_A = 10'h200;
        tick();
        write_en_C = 1'b0;
`ifdef MEM_WR_BYPASS_EN
        checkOutput("collision_A", data_out_A, 32'h2222_2222);
`else
        checkOutput("collision_A", data_out_A, 32'h1111_1111);
`endif
        tick();
        read_en_A = 1'b0;
        checkOutput("post_collision_A", data_out_A, 32'h2222_2222);

        // Wrapping clear with an ignored clr_start while busy
        dut.memory[10'h3FD] = 32'hDEAD_0001;
        dut.memory[10'h3FE] = 32'hDEAD_0002;
        dut.memory[10'h3FF] = 32'hDEAD_0003;
        dut.memory[10'h000] = 32'hDEAD_0004;
        dut.memory[10'h001] = 32'hDEAD_0005;
        dut.memory[10'h002] = 32'hDEAD_0006;
        dut.memory[10'h050] = 32'hDEAD_0050;
        applyStimulus(10'h3FE, 11'd4, -1, 2, busyCycles, doneCount, doneAt);
        checkOutput("wrap_busy_cycles", busyCycles, 32'd6);
        checkOutput("wrap_done_pulses", doneCount, 32'd1);
        checkOutput("wrap_3FD_kept", dut.memory[10'h3FD], 32'hDEAD_0001);
        checkOutput("wrap_3FE_zero", dut.memory[10'h3FE], 32'h0);
        checkOutput("wrap_3FF_zero", dut.memory[10'h3FF], 32'h0);
        checkOutput("wrap_000_zero", dut.memory[10'h000], 32'h0);
        checkOutput("wrap_001_zero", dut.memory[10'h001], 32'h0);
        checkOutput("wrap_002_kept", dut.memory[10'h002], 32'hDEAD_0006);
        checkOutput("restart_ignored", dut.memory[10'h050], 32'hDEAD_0050);

        // Stall by a port-C write in the first clear cycle
        for (int i = 0; i < 4; i++) dut.memory[10'h100 + i] = 32'hAAAA_0000 + i;
        applyStimulus(10'h100, 11'd3, 0, -1, busyCycles, doneCount, doneAt);
        checkOutput("stall_busy_cycles", busyCycles, 32'd6);
        checkOutput("stall_100_zero", dut.memory[10'h100], 32'h0);
        checkOutput("stall_101_zero", dut.memory[10'h101], 32'h0);
        checkOutput("stall_102_zero", dut.memory[10'h102], 32'h0);
        checkOutput("stall_103_kept", dut.memory[10'h103], 32'hAAAA_0003);
        checkOutput("stall_write_C", dut.memory[10'h300], 32'h0000_0005);
        checkOutput("stall_wr_count", {16'h0, wr_count}, 32'h3);

        // Zero-length clear
        dut.memory[10'h010] = 32'hBEEF_0010;
        applyStimulus(10'h010, 11'd0, -1, -1, busyCycles, doneCount, doneAt);
        checkOutput("len0_busy_cycles", busyCycles, 32'd2);
        checkOutput("len0_done_pulses", doneCount, 32'd1);
        checkOutput("len0_done_at", doneAt, 32'd1);
        checkOutput("len0_no_write", dut.memory[10'h010], 32'hBEEF_0010);

        // Reset aborts a running clear after two words
        for (int i = 0; i < 8; i++) dut.memory[10'h020 + i] = 32'hCCCC_0000 + i;
        clr_base = 10'h020; clr_len = 11'd8; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick(); tick();
        rstn = 1'b0;
        tick();
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_clr_done", {31'h0, clr_done}, 32'h0);
        checkOutput("abort_wr_count", {16'h0, wr_count}, 32'h0);
        rstn = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (clr_done || busy) doneCount++;
        end
        checkOutput("abort_no_done", doneCount, 32'd0);
        checkOutput("abort_020_zero", dut.memory[10'h020], 32'h0);
        checkOutput("abort_021_zero", dut.memory[10'h021], 32'h0);
        checkOutput("abort_022_kept", dut.memory[10'h022], 32'hCCCC_0002);
        checkOutput("abort_027_kept", dut.memory[10'h027], 32'hCCCC_0007);

        // wr_count saturation
        write_en_C = 1'b1; addr_C = 10'h3A0; data_in_C = 32'h1234_5678;
        for (int i = 0; i < 65534; i++) tick();
        checkOutput("wr_count_FFFE", {16'h0, wr_count}, 32'h0000_FFFE);
        tick(); tick();
        write_en_C = 1'b0;
        checkOutput("wr_count_sat", {16'h0, wr_count}, 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
